// File: rtl/sc_node_rr_arbiter.sv
// Round-robin arbiter that shares one SC node channel among NUM_SI requesters.
// A grant is held for a whole packet (or one beat) and beats leave through one output register.
module sc_node_rr_arbiter #(
    parameter  int NUM_SI   = 4,
    parameter  int PAYLD_W  = 304,
    parameter  int INFO_W   = 1,
    parameter  int LAST_BIT = 0,
    parameter  int PKT_MODE = 1,
    localparam int GW       = $clog2(NUM_SI)
) (
    input  logic                        sc_aclk,
    input  logic                        sc_aresetn,
    input  logic [NUM_SI-1:0]           s_sc_req,
    input  logic [NUM_SI-1:0]           s_sc_send,
    output logic [NUM_SI-1:0]           s_sc_recv,
    input  logic [NUM_SI*INFO_W-1:0]    s_sc_info,
    input  logic [NUM_SI*PAYLD_W-1:0]   s_sc_payld,
    output logic                        m_sc_req,
    output logic                        m_sc_send,
    input  logic                        m_sc_recv,
    output logic [INFO_W-1:0]           m_sc_info,
    output logic [PAYLD_W-1:0]          m_sc_payld,
    output logic                        grant_valid,
    output logic [GW-1:0]               grant_id
);

    // Handshake: a beat moves on a link in every cycle where send and recv are both high.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       grant_id_q, grant_id_d;
    logic                out_valid_q, out_valid_d;
    logic [PAYLD_W-1:0]  payld_q, payld_d;
    logic [INFO_W-1:0]   info_q, info_d;

    logic                pick_found;
    logic [GW-1:0]       pick_id;
    logic [GW:0]         scan_sum;
    logic [GW-1:0]       scan_idx;
    logic                g_send;
    logic [PAYLD_W-1:0]  g_payld;
    logic [INFO_W-1:0]   g_info;
    logic                g_recv;
    logic                g_accept;
    logic                g_end;

    // First requesting index at or after rr_ptr, wrapping at NUM_SI.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_SI; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (scan_sum >= (GW+1)'(NUM_SI)) begin
                scan_sum = scan_sum - (GW+1)'(NUM_SI);
            end
            scan_idx = scan_sum[GW-1:0];
            if (!pick_found && s_sc_req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_comb begin
        g_send  = 1'b0;
        g_payld = '0;
        g_info  = '0;
        for (int i = 0; i < NUM_SI; i++) begin
            if (GW'(i) == grant_id_q) begin
                g_send  = s_sc_send[i];
                g_payld = s_sc_payld[i*PAYLD_W +: PAYLD_W];
                g_info  = s_sc_info[i*INFO_W +: INFO_W];
            end
        end
    end

    // Accept is combinational from m_sc_recv so a full register can unload and reload in one cycle.
    assign g_recv    = (state_q == ST_BUSY) && (!out_valid_q || m_sc_recv);
    assign g_accept  = g_send && g_recv;
    assign g_end     = (PKT_MODE == 0) || g_payld[LAST_BIT];
    assign s_sc_recv = g_recv ? (NUM_SI'(1) << grant_id_q) : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_BUSY;
                    grant_id_d = pick_id;
                end
            end
            ST_BUSY: begin
                if (g_accept && g_end) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_id_q == GW'(NUM_SI-1)) ? '0 : grant_id_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        payld_d     = payld_q;
        info_d      = info_q;
        if (g_accept) begin
            out_valid_d = 1'b1;
            payld_d     = g_payld;
            info_d      = g_info;
        end else if (m_sc_recv) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
        if (!sc_aresetn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            out_valid_q <= 1'b0;
            payld_q     <= '0;
            info_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            out_valid_q <= out_valid_d;
            payld_q     <= payld_d;
            info_q      <= info_d;
        end
    end

    assign grant_valid = (state_q == ST_BUSY);
    assign grant_id    = grant_id_q;
    assign m_sc_send   = out_valid_q;
    assign m_sc_req    = out_valid_q || grant_valid;
    assign m_sc_payld  = payld_q;
    assign m_sc_info   = info_q;

endmodule

// File: tb/tb_sc_node_rr_arbiter.sv
// Bench for sc_node_rr_arbiter: packet-level round-robin reference model with random source/sink timing,
// plus directed reset, stall, rogue-sender and per-beat-mode sequences.
module tb_sc_node_rr_arbiter;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int IW = 1;
    localparam int GW = 2;

    logic              clk;
    logic              rst_n;

    logic [N-1:0]      s_req, s_send, s_recv;
    logic [N*IW-1:0]   s_info;
    logic [N*PW-1:0]   s_payld;
    logic              m_req, m_send, m_recv;
    logic [IW-1:0]     m_info;
    logic [PW-1:0]     m_payld;
    logic              gv;
    logic [GW-1:0]     gid;

    logic [N-1:0]      z_req, z_send, z_recv;
    logic [N*IW-1:0]   z_info;
    logic [N*PW-1:0]   z_payld;
    logic              z_mreq, z_msend, z_mrecv;
    logic [IW-1:0]     z_minfo;
    logic [PW-1:0]     z_mpayld;
    logic              z_gv;
    logic [GW-1:0]     z_gid;

    sc_node_rr_arbiter #(
        .NUM_SI(N), .PAYLD_W(PW), .INFO_W(IW), .LAST_BIT(0), .PKT_MODE(1)
    ) dut (
        .sc_aclk(clk), .sc_aresetn(rst_n),
        .s_sc_req(s_req), .s_sc_send(s_send), .s_sc_recv(s_recv),
        .s_sc_info(s_info), .s_sc_payld(s_payld),
        .m_sc_req(m_req), .m_sc_send(m_send), .m_sc_recv(m_recv),
        .m_sc_info(m_info), .m_sc_payld(m_payld),
        .grant_valid(gv), .grant_id(gid)
    );

    sc_node_rr_arbiter #(
        .NUM_SI(N), .PAYLD_W(PW), .INFO_W(IW), .LAST_BIT(0), .PKT_MODE(0)
    ) dut_beat (
        .sc_aclk(clk), .sc_aresetn(rst_n),
        .s_sc_req(z_req), .s_sc_send(z_send), .s_sc_recv(z_recv),
        .s_sc_info(z_info), .s_sc_payld(z_payld),
        .m_sc_req(z_mreq), .m_sc_send(z_msend), .m_sc_recv(z_mrecv),
        .m_sc_info(z_minfo), .m_sc_payld(z_mpayld),
        .grant_valid(z_gv), .grant_id(z_gid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int              checks   = 0;
    int              failures = 0;
    logic [PW-1:0]   src_q   [N][$];   // beats each source still has to send
    logic [PW-1:0]   mdl_q   [N][$];   // model copy of the same beats
    int              mdl_len [N][$];   // packet lengths per source, in order
    logic [PW:0]     exp_q[$];         // expected output beats {info, payload}
    int              exp_gnt_q[$];     // expected grant order
    int              mdl_ptr;
    int              pkt_cnt = 0;
    int              send_pct, recv_pct, stall_left;
    logic [N-1:0]    rogue;

    logic [N-1:0]    s_fire;
    logic            o_fire;
    bit              have_prev;
    logic            prev_gv, prev_hold, prev_acc, prev_info, samp_msend;
    logic [N-1:0]    prev_req;
    logic [PW-1:0]   prev_payld, prev_acc_beat;
    logic [GW-1:0]   prev_gid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic load_pkt(input int src, input int len);
        logic [PW-1:0] beat;
        for (int b = 0; b < len; b++) begin
            beat = {4'(src), 12'(pkt_cnt), 8'(b), 7'($urandom), (b == len - 1)};
            src_q[src].push_back(beat);
            mdl_q[src].push_back(beat);
        end
        mdl_len[src].push_back(len);
        pkt_cnt++;
    endtask

    // Every loaded source keeps requesting until its queue is empty, so the grant
    // order is a plain rotation over the sources that still own packets.
    task automatic build_model();
        int s, c, len;
        logic [PW-1:0] b;
        forever begin
            s = -1;
            for (int k = 0; k < N; k++) begin
                c = (mdl_ptr + k) % N;
                if (s < 0 && mdl_len[c].size() != 0) s = c;
            end
            if (s < 0) break;
            exp_gnt_q.push_back(s);
            len = mdl_len[s].pop_front();
            for (int j = 0; j < len; j++) begin
                b = mdl_q[s].pop_front();
                exp_q.push_back({b[1], b});
            end
            mdl_ptr = (s + 1) % N;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_inputs();
        logic [PW-1:0] cur;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) begin
                cur                 = src_q[i][0];
                s_req[i]            = 1'b1;
                s_send[i]           = ($urandom_range(0, 99) < send_pct);
                s_payld[i*PW +: PW] = cur;
                s_info[i*IW +: IW]  = cur[1];
            end else begin
                s_req[i]            = 1'b0;
                s_send[i]           = rogue[i];
                s_payld[i*PW +: PW] = {4'(i), 28'hFFFFFF1};
                s_info[i*IW +: IW]  = 1'b1;
            end
        end
        if (stall_left > 0) begin
            m_recv = 1'b0;
            stall_left--;
        end else begin
            m_recv = ($urandom_range(0, 99) < recv_pct);
        end
    endtask

    task automatic sample_and_check();
        logic [N-1:0] gmask;
        logic [PW:0]  e;
        s_fire = s_send & s_recv;
        o_fire = m_send & m_recv;
        gmask  = gv ? (N'(1) << gid) : '0;
        check("recv_only_granted", 64'(s_recv & ~gmask), 64'(0));
        if (gv) check("recv_granted", 64'(s_recv[gid]), 64'(!m_send || m_recv));
        check("m_req", 64'(m_req), 64'(m_send || gv));
        if (have_prev) begin
            if (!prev_gv) begin
                check("grant_follows_req", 64'(gv), 64'(prev_req != 0));
                if (gv) begin
                    check("grant_pending", 64'(exp_gnt_q.size() != 0), 64'(1));
                    if (exp_gnt_q.size() != 0) check("grant_id", 64'(gid), 64'(exp_gnt_q.pop_front()));
                end
            end else if (gv) begin
                check("grant_hold", 64'(gid), 64'(prev_gid));
            end
            if (prev_hold) begin
                check("hold_send", 64'(m_send), 64'(1));
                check("hold_payld", 64'(m_payld), 64'(prev_payld));
                check("hold_info", 64'(m_info), 64'(prev_info));
            end
            if (prev_acc) begin
                check("latency_send", 64'(m_send), 64'(1));
                check("latency_payld", 64'(m_payld), 64'(prev_acc_beat));
                check("release_on_last", 64'(gv), 64'(!prev_acc_beat[0]));
            end
        end
        if (o_fire) begin
            check("out_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_payld", 64'(m_payld), 64'(e[PW-1:0]));
                check("out_info", 64'(m_info), 64'(e[PW]));
            end
        end
        prev_gv   = gv;
        prev_gid  = gid;
        prev_req  = s_req;
        prev_hold = m_send && !m_recv;
        prev_payld = m_payld;
        prev_info = m_info[0];
        prev_acc  = |s_fire;
        prev_acc_beat = '0;
        for (int i = 0; i < N; i++) if (s_fire[i]) prev_acc_beat = s_payld[i*PW +: PW];
        samp_msend = m_send;
        have_prev = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample_and_check();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        drive_inputs();
    endtask

    task automatic run_drain(input int budget);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (!done && n < budget) begin
            cycle();
            n++;
            done = (exp_q.size() == 0) && (exp_gnt_q.size() == 0);
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
        end
        check("drain_done", 64'(done), 64'(1));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_grant_valid"}, 64'(gv), 64'(0));
        check({pfx, "_grant_id"}, 64'(gid), 64'(0));
        check({pfx, "_m_req"}, 64'(m_req), 64'(0));
        check({pfx, "_m_send"}, 64'(m_send), 64'(0));
        check({pfx, "_m_payld"}, 64'(m_payld), 64'(0));
        check({pfx, "_m_info"}, 64'(m_info), 64'(0));
        check({pfx, "_s_recv"}, 64'(s_recv), 64'(0));
        check({pfx, "_beat_m_send"}, 64'(z_msend), 64'(0));
        check({pfx, "_beat_m_req"}, 64'(z_mreq), 64'(0));
        check({pfx, "_beat_grant_valid"}, 64'(z_gv), 64'(0));
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        s_req  = '0; s_send = '0; s_info = '0; s_payld = '0; m_recv = 1'b0;
        z_req  = '0; z_send = '0; z_info = '0; z_payld = '0; z_mrecv = 1'b0;
        rogue  = '0;
        stall_left = 0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
            mdl_len[i].delete();
        end
        exp_q.delete();
        exp_gnt_q.delete();
        mdl_ptr   = 0;
        have_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int got_q[$];
        send_pct = 100;
        recv_pct = 100;

        // single 3-beat packet from source 0, then rotation continues from source 1
        do_reset();
        load_pkt(0, 3);
        build_model();
        drive_inputs();
        run_drain(100);
        load_pkt(0, 1);
        load_pkt(1, 1);
        build_model();
        drive_inputs();
        run_drain(100);

        // all four sources, two 2-beat packets each, from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            load_pkt(i, 2);
            load_pkt(i, 2);
        end
        build_model();
        drive_inputs();
        run_drain(200);

        // output stalled for 5 cycles while holding a beat
        load_pkt(1, 6);
        build_model();
        drive_inputs();
        n = 0;
        while (!samp_msend && n < 20) begin
            cycle();
            n++;
        end
        check("stall_reached", 64'(samp_msend), 64'(1));
        stall_left = 5;
        drive_inputs();
        run_drain(200);

        // random traffic with random source and sink pacing
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) load_pkt(i, $urandom_range(1, 4));
            end
            send_pct = $urandom_range(40, 100);
            recv_pct = $urandom_range(30, 100);
            build_model();
            drive_inputs();
            run_drain(3000);
        end

        // source 3 asserts send without request; nothing from it may be taken
        rogue = 4'b1000;
        for (int i = 0; i < 3; i++) load_pkt(i, $urandom_range(1, 3));
        send_pct = 80;
        recv_pct = 70;
        build_model();
        drive_inputs();
        run_drain(1000);
        rogue = '0;

        // reset during beat 2 of a 4-beat packet, then restart from index 0
        send_pct = 100;
        recv_pct = 100;
        load_pkt(1, 4);
        build_model();
        drive_inputs();
        n = 0;
        while (src_q[1].size() > 3 && n < 50) begin
            cycle();
            n++;
        end
        check("reset_mid_reached", 64'(src_q[1].size()), 64'(3));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        do_reset();
        load_pkt(2, 2);
        load_pkt(0, 2);
        build_model();
        drive_inputs();
        run_drain(100);

        // per-beat arbitration instance: sources 0 and 1 stream single beats
        z_req   = 4'b0011;
        z_send  = 4'b0011;
        z_mrecv = 1'b1;
        for (int i = 0; i < N; i++) z_payld[i*PW +: PW] = {4'(i), 28'h0000002};
        repeat (12) begin
            @(negedge clk);
            if (z_msend && z_mrecv) got_q.push_back(int'(z_mpayld[31:28]));
        end
        for (int k = 0; k < 4; k++) begin
            check("beat_mode_src", 64'(got_q.size() > k ? got_q[k] : -1), 64'(k % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
